sonar_sampler: RTL

Control and post-processing stage around the HC-SR04 sonar driver. Issues periodic one-cycle measure requests and captures the 8-bit distance on the driver's ready pulse. Detects lost echoes by timeout and pulses a recovery reset to the driver. Keeps a moving average and a near-object flag for downstream logic.

---
 rtl/sonar_sampler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sonar_sampler.sv
// sonar_sampler: periodic measure sequencer and result post-processing for the
// HC-SR04 sonar driver. Issues measure strobes, captures distance on ready,
// recovers the driver after lost echoes, and keeps a moving average plus a
// near-object flag.
module sonar_sampler #(
   parameter int unsigned FREQ        = 50_000_000,
   parameter int unsigned PERIOD_US   = 60000,
   parameter int unsigned TIMEOUT_US  = 50000,
   parameter int unsigned RST_CYCLES  = 4,
   parameter int unsigned AVG_LOG2    = 2,
   parameter int unsigned NEAR_THRESH = 20,
   parameter int unsigned MAX_MISSES  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   output logic       measure,
   input  logic       ready,
   input  logic [7:0] distance,
   output logic       sonar_rst,
   output logic [7:0] avg_distance,
   output logic       avg_valid,
   output logic       near,
   output logic       fault
);

   localparam logic [31:0] PERIOD_CYC = 32'(FREQ / 1_000_000 * PERIOD_US);
   localparam logic [31:0] TO_CYC     = 32'(FREQ / 1_000_000 * TIMEOUT_US);
   localparam int          DEPTH      = 1 << AVG_LOG2;
   localparam int          SUM_W      = 8 + AVG_LOG2;
   localparam int          WP_W       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int          FILL_W     = AVG_LOG2 + 1;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT,
      RECOVER,
      GAP
   } state_t;

   state_t            state;
   logic [31:0]       per_cnt;
   logic [31:0]       to_cnt;
   logic [31:0]       rst_cnt;
   logic [31:0]       miss_cnt;

   logic [7:0]        sbuf [DEPTH];
   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  new_sum;
   logic [WP_W-1:0]   wp;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] new_fill;
   logic              accept;

   // Truncating average of the window sum.
   function automatic logic [7:0] avg_of(input logic [SUM_W-1:0] s);
      avg_of = 8'(s >> AVG_LOG2);
   endfunction

   // Near-object decision on an average value.
   function automatic logic near_of(input logic [7:0] a);
      near_of = (32'(a) < NEAR_THRESH);
   endfunction

   // A sample is taken only while waiting for the driver and still enabled.
   always_comb begin
      accept   = (state == WAIT) && enable && ready;
      new_sum  = sum - SUM_W'(sbuf[wp]) + SUM_W'(distance);
      new_fill = (fill == FILL_W'(DEPTH)) ? fill : fill + FILL_W'(1);
   end

   // Sample ring buffer with running sum; the sum always equals the buffer total.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         wp   <= '0;
         fill <= '0;
         for (int i = 0; i < DEPTH; i++) sbuf[i] <= 8'd0;
      end else if (accept) begin
         sbuf[wp] <= distance;
         sum      <= new_sum;
         wp       <= (wp == WP_W'(DEPTH - 1)) ? '0 : wp + WP_W'(1);
         fill     <= new_fill;
      end
   end

   // Average outputs, one cycle after an accept that leaves the window full.
   always_ff @(posedge clk) begin
      if (rst) begin
         avg_distance <= 8'd0;
         avg_valid    <= 1'b0;
         near         <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         if (accept && (new_fill == FILL_W'(DEPTH))) begin
            avg_distance <= avg_of(new_sum);
            avg_valid    <= 1'b1;
            near         <= near_of(avg_of(new_sum));
         end
      end
   end

   // Measurement sequencer: the period counter lags the measure pulse by one
   // cycle, so GAP leaves at PERIOD_CYC-2 to space measures PERIOD_CYC apart.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         measure   <= 1'b0;
         sonar_rst <= 1'b0;
         fault     <= 1'b0;
         miss_cnt  <= 32'd0;
         per_cnt   <= 32'd0;
         to_cnt    <= 32'd0;
         rst_cnt   <= 32'd0;
      end else if (!enable) begin
         state     <= IDLE;
         measure   <= 1'b0;
         sonar_rst <= 1'b0;
         fault     <= 1'b0;
         miss_cnt  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               state   <= ARM;
               measure <= 1'b1;
            end
            ARM: begin
               measure <= 1'b0;
               per_cnt <= 32'd0;
               to_cnt  <= 32'd0;
               state   <= WAIT;
            end
            WAIT: begin
               per_cnt <= per_cnt + 32'd1;
               to_cnt  <= to_cnt + 32'd1;
               if (ready) begin
                  miss_cnt <= 32'd0;
                  state    <= GAP;
               end else if (to_cnt == TO_CYC - 32'd1) begin
                  if (miss_cnt < MAX_MISSES) miss_cnt <= miss_cnt + 32'd1;
                  if (miss_cnt + 32'd1 >= MAX_MISSES) fault <= 1'b1;
                  sonar_rst <= 1'b1;
                  rst_cnt   <= 32'd0;
                  state     <= RECOVER;
               end
            end
            RECOVER: begin
               per_cnt <= per_cnt + 32'd1;
               rst_cnt <= rst_cnt + 32'd1;
               if (rst_cnt >= 32'(RST_CYCLES - 1)) begin
                  sonar_rst <= 1'b0;
                  state     <= GAP;
               end
            end
            GAP: begin
               per_cnt <= per_cnt + 32'd1;
               if (per_cnt >= PERIOD_CYC - 32'd2) begin
                  measure <= 1'b1;
                  state   <= ARM;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
